// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter/sequencer sharing one square-root core among N_REQ clients.
// Optional WAIT timeout abort is built only when SQRT_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no op in flight; arbitrate among active requests
// ISSUE | one-cycle start pulse to the core, grant asserted
// WAIT  | grant and radicand held until the core reports done
// RESP  | one-cycle response pulse to the winner, pointer advances
module sqrt_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [16*N_REQ-1:0]  valor_i,
    output logic [N_REQ-1:0]     gnt_o,
    output logic [N_REQ-1:0]     rsp_valid_o,
    output logic [7:0]           rsp_root_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 core_start_o,
    output logic [15:0]          core_valor_o,
    input  logic                 core_ready_i,
    input  logic [7:0]           core_root_i
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_win;
    logic [15:0]      r_valor;
    logic [7:0]       r_root;

    logic [IW-1:0]    w_sel;
    logic             w_found;
    logic [IW:0]      w_cand;
    logic [IW-1:0]    w_ptr_inc;
    logic [N_REQ-1:0] w_onehot;
    logic             w_timeout;
    logic             w_err;

    // Scan ptr, ptr+1, ... wrapping at N_REQ; first active request wins.
    always_comb begin
        w_sel   = r_ptr;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(N_REQ)) begin
                w_cand = w_cand - (IW+1)'(N_REQ);
            end
            if (!w_found && req_i[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[IW-1:0];
            end
        end
    end

    assign w_ptr_inc = (r_win == IW'(N_REQ-1)) ? '0 : r_win + 1'b1;
    assign w_onehot  = N_REQ'(1) << r_win;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] r_tcnt;
    logic           r_err;

    assign w_timeout = (r_state == S_WAIT) && (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));
    assign w_err     = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_tcnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            // A done pulse in the timeout cycle still counts as success.
            if (r_state == S_WAIT) begin
                if (core_ready_i) begin
                    r_err <= 1'b0;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign w_err            = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (core_ready_i || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_o        = '0;
        rsp_valid_o  = '0;
        rsp_err_o    = 1'b0;
        core_start_o = 1'b0;
        busy_o       = (r_state != S_IDLE);
        case (r_state)
            S_ISSUE: begin
                gnt_o        = w_onehot;
                core_start_o = 1'b1;
            end
            S_WAIT: gnt_o = w_onehot;
            S_RESP: begin
                gnt_o       = w_onehot;
                rsp_valid_o = w_onehot;
                rsp_err_o   = w_err;
            end
            default: ;
        endcase
    end

    assign core_valor_o = r_valor;
    assign rsp_root_o   = r_root;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_valor <= '0;
            r_root  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_found) begin
                r_win   <= w_sel;
                r_valor <= valor_i[{w_sel, 4'b0000} +: 16];
            end
            if (r_state == S_WAIT) begin
                if (core_ready_i) begin
                    r_root <= core_root_i;
                end else if (w_timeout) begin
                    r_root <= 8'h00;
                end
            end
            if (r_state == S_RESP) begin
                r_ptr <= w_ptr_inc;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter; the bench itself plays the square-root core.
// The timeout scenario runs only when SQRT_ARB_TIMEOUT_EN is defined.
module tb_sqrt_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_i;
    logic [63:0] valor_i;
    logic [3:0]  gnt_o;
    logic [3:0]  rsp_valid_o;
    logic [7:0]  rsp_root_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        core_start_o;
    logic [15:0] core_valor_o;
    logic        core_ready_i;
    logic [7:0]  core_root_i;

    int n_cmp = 0;
    int n_bad = 0;

    sqrt_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .valor_i      (valor_i),
        .gnt_o        (gnt_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_root_o   (rsp_root_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o),
        .core_start_o (core_start_o),
        .core_valor_o (core_valor_o),
        .core_ready_i (core_ready_i),
        .core_root_i  (core_root_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete op from IDLE with a single WAIT cycle before done.
    task automatic run_op(input string tag, input logic [3:0] exp_gnt,
                          input logic [15:0] exp_valor, input logic [7:0] root,
                          input logic [3:0] req_after);
        tick();
        chk({tag, "_issue_gnt"}, 16'(gnt_o), 16'(exp_gnt));
        chk({tag, "_issue_start"}, 16'(core_start_o), 16'd1);
        chk({tag, "_issue_valor"}, core_valor_o, exp_valor);
        chk({tag, "_issue_busy"}, 16'(busy_o), 16'd1);
        tick();
        chk({tag, "_wait_start"}, 16'(core_start_o), 16'd0);
        chk({tag, "_wait_gnt"}, 16'(gnt_o), 16'(exp_gnt));
        chk({tag, "_wait_valid"}, 16'(rsp_valid_o), 16'd0);
        core_ready_i = 1'b1;
        core_root_i  = root;
        tick();
        chk({tag, "_resp_valid"}, 16'(rsp_valid_o), 16'(exp_gnt));
        chk({tag, "_resp_root"}, 16'(rsp_root_o), 16'(root));
        chk({tag, "_resp_err"}, 16'(rsp_err_o), 16'd0);
        core_ready_i = 1'b0;
        core_root_i  = 8'h00;
        req_i        = req_after;
        tick();
        chk({tag, "_idle_valid"}, 16'(rsp_valid_o), 16'd0);
        chk({tag, "_idle_busy"}, 16'(busy_o), 16'd0);
    endtask

    logic [3:0]  fair_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [15:0] fair_val  [5] = '{16'd65535, 16'd0, 16'd144, 16'd10000, 16'd65535};
    logic [7:0]  fair_root [5] = '{8'd255, 8'd0, 8'd12, 8'd100, 8'd255};

    initial begin
        rst_n        = 1'b0;
        req_i        = 4'b0000;
        valor_i      = 64'd0;
        core_ready_i = 1'b0;
        core_root_i  = 8'h00;
        #2;
        chk("rst_gnt", 16'(gnt_o), 16'd0);
        chk("rst_busy", 16'(busy_o), 16'd0);
        chk("rst_start", 16'(core_start_o), 16'd0);
        chk("rst_valor", core_valor_o, 16'd0);
        chk("rst_valid", 16'(rsp_valid_o), 16'd0);
        chk("rst_root", 16'(rsp_root_o), 16'd0);
        chk("rst_err", 16'(rsp_err_o), 16'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Single request: 144 -> 12, three-cycle latency
        req_i          = 4'b0001;
        valor_i[15:0]  = 16'd144;
        run_op("t1", 4'b0001, 16'd144, 8'd12, 4'b0000);
        tick();
        chk("t1_root_hold", 16'(rsp_root_o), 16'd12);
        chk("t1_stay_idle", 16'(busy_o), 16'd0);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        // Fairness with all four requesting continuously
        req_i   = 4'b1111;
        valor_i = {16'd10000, 16'd144, 16'd0, 16'd65535};
        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("fair%0d", i), fair_gnt[i], fair_val[i], fair_root[i],
                   (i == 4) ? 4'b0000 : 4'b1111);
        end

        // Requester 1, radicand changed during WAIT, done pulse in ISSUE ignored
        req_i          = 4'b0010;
        valor_i[31:16] = 16'd81;
        tick();
        chk("t3_issue_gnt", 16'(gnt_o), 16'b0010);
        chk("t3_issue_valor", core_valor_o, 16'd81);
        core_ready_i = 1'b1;
        core_root_i  = 8'hAA;
        tick();
        core_ready_i   = 1'b0;
        core_root_i    = 8'h00;
        valor_i[31:16] = 16'd4;
        chk("t3_wait_busy", 16'(busy_o), 16'd1);
        chk("t3_wait_valid", 16'(rsp_valid_o), 16'd0);
        tick();
        chk("t3_wait_valor", core_valor_o, 16'd81);
        chk("t3_still_wait", 16'(rsp_valid_o), 16'd0);
        core_ready_i = 1'b1;
        core_root_i  = 8'd9;
        tick();
        chk("t3_resp_valid", 16'(rsp_valid_o), 16'b0010);
        chk("t3_resp_root", 16'(rsp_root_o), 16'd9);
        core_ready_i = 1'b0;
        req_i        = 4'b0000;
        tick();

        // Reset during WAIT abandons the op and clears the pointer
        req_i          = 4'b1000;
        valor_i[63:48] = 16'd400;
        tick();
        chk("t4_issue_gnt", 16'(gnt_o), 16'b1000);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_gnt", 16'(gnt_o), 16'd0);
        chk("t4_rst_busy", 16'(busy_o), 16'd0);
        chk("t4_rst_start", 16'(core_start_o), 16'd0);
        chk("t4_rst_valor", core_valor_o, 16'd0);
        chk("t4_rst_valid", 16'(rsp_valid_o), 16'd0);
        chk("t4_rst_root", 16'(rsp_root_o), 16'd0);
        req_i = 4'b0000;
        #1;
        rst_n = 1'b1;
        tick();
        chk("t4_post_valid0", 16'(rsp_valid_o), 16'd0);
        tick();
        chk("t4_post_valid1", 16'(rsp_valid_o), 16'd0);
        chk("t4_post_busy", 16'(busy_o), 16'd0);
        req_i          = 4'b1010;
        valor_i[31:16] = 16'd25;
        run_op("t4_ptr0", 4'b0010, 16'd25, 8'd5, 4'b0000);

        // Spurious done in IDLE, then requester 2 drops its request mid-op
        core_ready_i = 1'b1;
        core_root_i  = 8'h55;
        tick();
        chk("t6_spur_busy", 16'(busy_o), 16'd0);
        chk("t6_spur_start", 16'(core_start_o), 16'd0);
        chk("t6_spur_gnt", 16'(gnt_o), 16'd0);
        core_ready_i   = 1'b0;
        core_root_i    = 8'h00;
        req_i          = 4'b0100;
        valor_i[47:32] = 16'd49;
        tick();
        chk("t6_issue_gnt", 16'(gnt_o), 16'b0100);
        req_i = 4'b0000;
        tick();
        chk("t6_wait_gnt", 16'(gnt_o), 16'b0100);
        core_ready_i = 1'b1;
        core_root_i  = 8'd7;
        tick();
        chk("t6_resp_valid", 16'(rsp_valid_o), 16'b0100);
        chk("t6_resp_root", 16'(rsp_root_o), 16'd7);
        core_ready_i = 1'b0;
        tick();
        req_i = 4'b1111;
        tick();
        chk("t6_ptr3_gnt", 16'(gnt_o), 16'b1000);
        chk("t6_ptr3_valor", core_valor_o, 16'd400);
        tick();
        core_ready_i = 1'b1;
        core_root_i  = 8'd20;
        tick();
        chk("t6_ptr3_valid", 16'(rsp_valid_o), 16'b1000);
        chk("t6_ptr3_root", 16'(rsp_root_o), 16'd20);
        core_ready_i = 1'b0;
        req_i        = 4'b0000;
        tick();

`ifdef SQRT_ARB_TIMEOUT_EN
        // Core never answers: abort after 8 WAIT cycles
        req_i = 4'b0001;
        tick();
        chk("to_issue_gnt", 16'(gnt_o), 16'b0001);
        req_i = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("to_wait%0d_valid", i), 16'(rsp_valid_o), 16'd0);
        end
        tick();
        chk("to_resp_valid", 16'(rsp_valid_o), 16'b0001);
        chk("to_resp_err", 16'(rsp_err_o), 16'd1);
        chk("to_resp_root", 16'(rsp_root_o), 16'd0);
        tick();
        // Done on the 8th WAIT cycle wins over the timeout
        req_i          = 4'b0010;
        valor_i[31:16] = 16'd36;
        tick();
        chk("to2_issue_gnt", 16'(gnt_o), 16'b0010);
        req_i = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) begin
                core_ready_i = 1'b1;
                core_root_i  = 8'd6;
            end
        end
        tick();
        chk("to2_resp_valid", 16'(rsp_valid_o), 16'b0010);
        chk("to2_resp_err", 16'(rsp_err_o), 16'd0);
        chk("to2_resp_root", 16'(rsp_root_o), 16'd6);
        core_ready_i = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one square-root core (16-bit radicand, 8-bit root) between N_REQ requesters.
- Accepts level requests and latches the winner's radicand.
- Issues a one-cycle start to the core, waits for the core's done pulse, and returns the root to the granted requester.
- Sits between client blocks and the single square-root instance at the top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, max WAIT cycles before abort; used only when SQRT_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  N_REQ  per-requester request level.
- valor_i  in  16*N_REQ  radicands; requester k uses bits [16k+15:16k].
- gnt_o  out  N_REQ  one-hot grant, held from ISSUE through RESP.
- rsp_valid_o  out  N_REQ  one-cycle response pulse to the granted requester.
- rsp_root_o  out  8  root result, valid when any rsp_valid_o bit is 1.
- rsp_err_o  out  1  timeout flag, qualified by rsp_valid_o.
- busy_o  out  1  high whenever state is not IDLE.
- core_start_o  out  1  one-cycle start pulse to the core.
- core_valor_o  out  16  radicand to the core, stable from ISSUE through WAIT.
- core_ready_i  in  1  core done pulse.
- core_root_i  in  8  core result, sampled when core_ready_i=1.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, round-robin pointer=0.
  - All outputs 0; internal radicand and root registers 0.
  - Reset mid-operation abandons the op; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req_i != 0, select the first set bit scanning pointer, pointer+1, ... mod N_REQ.
  - Latch the winner index and its radicand; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - core_start_o=1, gnt_o one-hot set, core_valor_o=latched radicand.
  - core_ready_i is ignored in this cycle.
  - Go to WAIT.
- WAIT:
  - Hold gnt_o and core_valor_o; core_start_o=0.
  - When core_ready_i=1, capture core_root_i and go to RESP.
- RESP (exactly 1 cycle):
  - rsp_valid_o[winner]=1, rsp_root_o=captured root, rsp_err_o as computed.
  - Pointer <= (winner+1) mod N_REQ.
  - Next state is IDLE.
  - rsp_root_o holds its last value after RESP; it is only meaningful with rsp_valid_o.
- Latency: request sampled in IDLE at cycle T gives start at T+1 and response at D+1, where D is the cycle core_ready_i is seen (D >= T+2).
  - Minimum request-to-response latency: 3 cycles.
  - Back-to-back ops: next arbitration happens in the IDLE cycle after RESP (4-cycle minimum per op).
- Request rules:
  - A requester keeps req_i high until its rsp_valid_o pulse.
  - The radicand is latched at arbitration; later valor_i changes have no effect on the current op.
  - If req_i drops mid-op, the op completes and the response is still pulsed (requester may ignore it).
  - If req_i is still high in the IDLE after RESP, it counts as a new request at lowest round-robin priority.
- Fairness: with all requests asserted continuously, grants rotate 0,1,2,...,N_REQ-1,0,...
- A core_ready_i pulse in IDLE, ISSUE or RESP is ignored; no state change.
- Widths: all radicands are 16-bit unsigned; the root is 8-bit unsigned and passed through unchanged.

Optional Feature:
- SQRT_ARB_TIMEOUT_EN defined:
  - A counter, cleared in ISSUE, increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without core_ready_i, go to RESP with rsp_err_o=1 and rsp_root_o=8'h00.
  - If core_ready_i and the timeout coincide, core_ready_i wins and rsp_err_o=0.
- Not defined:
  - WAIT lasts indefinitely, no counter is built, and rsp_err_o is tied to 0.

Test Plan:
- Reset, then req_i=4'b0001, valor_i[15:0]=16'd144, core model answers 12 after 1 WAIT cycle -> start at T+1, rsp_valid_o=4'b0001 at T+3, rsp_root_o=8'd12, rsp_err_o=0.
- req_i=4'b1111 held continuously with 4 distinct radicands -> gnt_o sequence 0001,0010,0100,1000,0001; each root correct (e.g. 16'd65535 -> 8'd255, 16'd0 -> 8'd0).
- Grant to requester 1 with valor=16'd81, then change valor_i[31:16] to 16'd4 during WAIT -> core_valor_o stays 16'd81 and rsp_root_o=8'd9.
- Assert rst_n=0 during WAIT, then release -> all outputs 0, no rsp_valid_o pulse, and the next request is arbitrated from pointer 0.
- With SQRT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, core never ready -> rsp_valid_o pulses after 8 WAIT cycles with rsp_err_o=1 and rsp_root_o=8'h00; with core_ready_i on the 8th cycle -> rsp_err_o=0.
- Spurious core_ready_i in IDLE, and requester 2 drops req mid-op -> state stays IDLE on the spurious pulse; the dropped op still gives rsp_valid_o[2]=1 and the pointer advances to 3.
